hc194_deser: RTL and testbench
==============================

Name: hc194_deser

Overview:
- Serial-to-parallel receiver: the far end of a serial link whose transmitter is a HC194-style universal shift register run in shift-right or shift-left mode.
- Collects W serially-clocked bits per frame and presents the assembled word on a held parallel output.
- Output uses a valid/ready handshake with sticky overrun detection.
- Sits between the serial pin interface and downstream parallel logic, on the same clock as the transmitter-side logic.

Parameters:
- W, 4, word width in bits (minimum 2); output indexed [0:W-1].

Ports:
- CP  input  1  clock, rising-edge.
- MR  input  1  reset, synchronous, active-high.
- SDI  input  1  serial data bit.
- SEN  input  1  bit strobe; SDI is sampled only on CP edges where SEN=1.
- FS  input  1  frame start; qualified by SEN=1, marks SDI as bit 1 of a new frame.
- DIR  input  1  0 = shift-right order (bits enter at Q[0]); 1 = shift-left order (bits enter at Q[W-1]).
- READY  input  1  downstream accepts Q when VALID=1.
- CLR_OVR  input  1  clears OVR.
- Q  output  [0:W-1]  last completed word, registered.
- VALID  output  1  Q holds an unconsumed word.
- OVR  output  1  sticky overrun flag.
- BUSY  output  1  a frame is in progress (state SHIFT).

Behaviour:
- Reset: MR=1 at a CP edge clears the internal shift register, bit counter, Q=0, VALID=0, OVR=0, BUSY=0 and forces state IDLE. MR has priority over every other input.
- States: IDLE and SHIFT. BUSY=1 exactly in SHIFT.
- IDLE:
  - SEN=1 & FS=1 captures SDI as bit 1, sets count=1, latches DIR for the frame, and moves to SHIFT.
  - SEN=1 & FS=0 is ignored.
- SHIFT:
  - Each SEN=1 edge shifts SDI in and increments count.
  - SEN=0 cycles are ignored, so gaps of any length are allowed.
- Shift rules:
  - DIR=0: new bit goes into sr[0] and sr[i] moves to sr[i+1]. The first-received bit ends in Q[W-1].
  - DIR=1: new bit goes into sr[W-1] and sr[i] moves to sr[i-1]. The first-received bit ends in Q[0].
  - DIR changes mid-frame are ignored; the value latched at frame start governs.
- Completion: on the edge sampling bit W, the assembled word (including that bit) is written to Q and VALID is set on that same edge (zero extra latency). State returns to IDLE, count=0.
- Restart: SEN=1 & FS=1 while in SHIFT discards the partial frame, takes SDI as bit 1 (count=1), and relatches DIR. Nothing is written to Q.
- Handshake: VALID&READY at an edge consumes the word and VALID=0 next cycle. Q keeps its value until the next load.
- Simultaneous consume and completion at one edge: the new word loads, VALID stays 1, OVR is unchanged.
- Overrun: completion while VALID=1 & READY=0 drops the new word (Q unchanged, VALID stays 1) and sets OVR=1.
- OVR clears only on MR or on CLR_OVR=1. If CLR_OVR and a new overrun occur at the same edge, OVR=1 (set wins).
- Counter width is clog2(W+1). Count never exceeds W and there is no wrap beyond W.

Test Plan:
- Reset (W=4): MR=1 for one edge mid-activity -> Q=0000, VALID=0, OVR=0, BUSY=0. A following SEN=1,FS=0 is ignored (BUSY stays 0).
- Shift-right frame (DIR=0): bits 1,0,1,1 with FS on the first bit, READY=0 -> after the 4th SEN edge Q[0:3]=1,1,0,1 and VALID=1. BUSY=1 during bits 2-4 and 0 after completion.
- Shift-left frame with gaps (DIR=1): same bits 1,0,1,1 with 3 idle SEN=0 cycles between each -> Q[0:3]=1,0,1,1 and VALID=1. Toggling DIR mid-frame has no effect.
- Overrun and clear (READY=0):
  - First frame 1,0,1,1 (DIR=0) -> Q[0:3]=1,1,0,1.
  - Second frame 0,0,0,0 -> Q still 1,1,0,1, VALID=1, OVR=1.
  - CLR_OVR pulse -> OVR=0. READY pulse -> VALID=0.
- Consume/complete collision: hold READY=1 so the edge sampling bit 4 of a frame coincides with VALID=1 -> new word in Q, VALID=1, OVR=0.
- Restart/reset mid-frame:
  - FS re-asserted after 2 bits, then 4 more bits 0,1,1,0 (DIR=0) -> Q[0:3]=0,1,1,0. The partial frame is dropped.
  - MR after 3 bits of a frame -> BUSY=0 and Q=0000; the 4th bit without FS is ignored.

Source files
------------

// File: rtl/hc194_deser.sv
// hc194_deser: serial-to-parallel receiver for a HC194-style shift-register link, valid/ready output with sticky overrun
module hc194_deser #(
  parameter int W = 4
) (
  input  logic         CP,
  input  logic         MR,
  input  logic         SDI,
  input  logic         SEN,
  input  logic         FS,
  input  logic         DIR,
  input  logic         READY,
  input  logic         CLR_OVR,
  output logic [0:W-1] Q,
  output logic         VALID,
  output logic         OVR,
  output logic         BUSY
);
  localparam int CW = $clog2(W + 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t        state_q, state_d;
  logic [0:W-1]  sr_q, sr_d, q_q, q_d, base, shifted;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d, valid_q, valid_d, ovr_q, ovr_d;
  logic          start, step, done, dir_use;
  always_comb begin
    start   = SEN & FS;
    step    = SEN & ~FS & (state_q == SHIFT);
    done    = step & (cnt_q == CW'(W - 1));
    dir_use = start ? DIR : dir_q;
    // a new frame shifts into a cleared register so stale bits never leak in
    base    = start ? '0 : sr_q;
    shifted = dir_use ? {base[1:W-1], SDI} : {SDI, base[0:W-2]};
    state_d = start ? SHIFT : done ? IDLE : state_q;
    cnt_d   = start ? CW'(1) : done ? '0 : step ? cnt_q + CW'(1) : cnt_q;
    dir_d   = start ? DIR : dir_q;
    sr_d    = (start | step) ? shifted : sr_q;
    q_d     = (done & (~valid_q | READY)) ? shifted : q_q;
    valid_d = done | (valid_q & ~READY);
    ovr_d   = (done & valid_q & ~READY) | (ovr_q & ~CLR_OVR);
  end
  always_ff @(posedge CP) begin
    if (MR) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      q_q     <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end
  assign Q     = q_q;
  assign VALID = valid_q;
  assign OVR   = ovr_q;
  assign BUSY  = (state_q == SHIFT);
endmodule

// File: tb/tb_hc194_deser.sv
// tb_hc194_deser: directed frames with a scoreboard of expected words popped on each valid/ready handshake
module tb_hc194_deser;
  logic       CP = 1'b0, MR = 1'b1, SDI = 1'b0, SEN = 1'b0, FS = 1'b0;
  logic       DIR = 1'b0, READY = 1'b0, CLR_OVR = 1'b0;
  logic [0:3] Q;
  logic       VALID, OVR, BUSY;
  logic [0:3] exp_q[$];
  int         n_chk = 0, n_fail = 0;
  hc194_deser #(.W(4)) dut (
    .CP(CP), .MR(MR), .SDI(SDI), .SEN(SEN), .FS(FS), .DIR(DIR),
    .READY(READY), .CLR_OVR(CLR_OVR), .Q(Q), .VALID(VALID), .OVR(OVR), .BUSY(BUSY)
  );
  always #5 CP = ~CP;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask
  always @(negedge CP) begin
    if (!MR && VALID === 1'b1 && READY) begin
      if (exp_q.size() == 0) check("unexpected_word", 32'(Q), 32'hffff_ffff);
      else check("word", 32'(Q), 32'(exp_q.pop_front()));
    end
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CP);
      #1;
    end
  endtask
  task automatic sbit(input logic b, input logic fs);
    SDI = b;
    FS  = fs;
    SEN = 1'b1;
    @(posedge CP);
    #1;
    SEN = 1'b0;
    FS  = 1'b0;
  endtask
  task automatic frame4(input logic [0:3] bits, input logic dir);
    DIR = dir;
    sbit(bits[0], 1'b1);
    for (int i = 1; i < 4; i++) sbit(bits[i], 1'b0);
  endtask
  task automatic consume;
    READY = 1'b1;
    idle(1);
    READY = 1'b0;
    check("valid_after_consume", 32'(VALID), 0);
  endtask
  initial begin
    idle(2);
    MR = 1'b0;
    check("rst_q", 32'(Q), 0);
    check("rst_valid", 32'(VALID), 0);
    check("rst_busy", 32'(BUSY), 0);
    sbit(1, 1);
    sbit(0, 0);
    check("busy_pre_mr", 32'(BUSY), 1);
    MR = 1'b1;
    idle(1);
    MR = 1'b0;
    check("mr_q", 32'(Q), 0);
    check("mr_valid", 32'(VALID), 0);
    check("mr_ovr", 32'(OVR), 0);
    check("mr_busy", 32'(BUSY), 0);
    sbit(1, 0);
    check("no_fs_ignored", 32'(BUSY), 0);
    DIR = 1'b0;
    sbit(1, 1);
    sbit(0, 0);
    check("sr_busy_b2", 32'(BUSY), 1);
    sbit(1, 0);
    check("sr_busy_b3", 32'(BUSY), 1);
    exp_q.push_back(4'b1101);
    sbit(1, 0);
    check("sr_busy_done", 32'(BUSY), 0);
    check("sr_valid", 32'(VALID), 1);
    check("sr_q", 32'(Q), 32'(4'b1101));
    consume();
    DIR = 1'b1;
    sbit(1, 1);
    exp_q.push_back(4'b1011);
    for (int i = 1; i < 4; i++) begin
      DIR = ~DIR;
      idle(3);
      sbit(i != 1, 0);
    end
    check("sl_q", 32'(Q), 32'(4'b1011));
    check("sl_valid", 32'(VALID), 1);
    consume();
    exp_q.push_back(4'b1101);
    frame4(4'b1011, 1'b0);
    check("ovr_first_clear", 32'(OVR), 0);
    sbit(0, 1);
    sbit(0, 0);
    sbit(0, 0);
    CLR_OVR = 1'b1;
    sbit(0, 0);
    CLR_OVR = 1'b0;
    check("ovr_q_kept", 32'(Q), 32'(4'b1101));
    check("ovr_valid", 32'(VALID), 1);
    check("ovr_set", 32'(OVR), 1);
    CLR_OVR = 1'b1;
    idle(1);
    CLR_OVR = 1'b0;
    check("ovr_cleared", 32'(OVR), 0);
    consume();
    exp_q.push_back(4'b1101);
    frame4(4'b1011, 1'b0);
    exp_q.push_back(4'b0111);
    sbit(1, 1);
    sbit(1, 0);
    sbit(1, 0);
    READY = 1'b1;
    sbit(0, 0);
    check("col_q", 32'(Q), 32'(4'b0111));
    check("col_valid", 32'(VALID), 1);
    check("col_ovr", 32'(OVR), 0);
    idle(1);
    READY = 1'b0;
    check("col_drained", 32'(VALID), 0);
    sbit(1, 1);
    sbit(1, 0);
    exp_q.push_back(4'b0110);
    sbit(0, 1);
    sbit(1, 0);
    sbit(1, 0);
    check("rs_busy", 32'(BUSY), 1);
    check("rs_no_load", 32'(VALID), 0);
    sbit(0, 0);
    check("rs_q", 32'(Q), 32'(4'b0110));
    check("rs_valid", 32'(VALID), 1);
    consume();
    sbit(1, 1);
    sbit(0, 0);
    sbit(1, 0);
    MR = 1'b1;
    idle(1);
    MR = 1'b0;
    check("mr2_busy", 32'(BUSY), 0);
    check("mr2_q", 32'(Q), 0);
    sbit(1, 0);
    check("mr2_bit4_busy", 32'(BUSY), 0);
    check("mr2_bit4_valid", 32'(VALID), 0);
    idle(2);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
